// File: rtl/reg_bank_sh.sv
// reg_bank_sh: configuration register bank with optional shadow/commit
// double-buffering, sticky per-register write lock, registered read-back
// port and a one-cycle write/lock error pulse.
module reg_bank_sh #(
  parameter int              DW      = 8,
  parameter int              NREG    = 3,
  parameter int              AW      = 2,
  parameter bit              SHADOW  = 1'b1,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               my_wr,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      Data,
  input  logic               lock,
  input  logic               commit,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic [NREG*DW-1:0] regs_flat,
  output logic [NREG-1:0]    locked,
  output logic               wr_err
);

  // Address decode shared by the write and lock paths
  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic [NREG-1:0]     w_wr_sel;
  logic                w_tgt_locked;
  logic                w_wr_ok;
  logic                w_lock_ok;
  logic                w_err_next;
  logic [DW-1:0]       w_rd_terms [NREG];
  logic [DW-1:0]       w_rd_word;

  logic [DW-1:0]       r_rd_data;
  logic                r_rd_valid;
  logic                r_wr_err;

  assign w_wr_in_range = (int'(wr_addr) < NREG);
  assign w_rd_in_range = (int'(rd_addr) < NREG);

  // Lock status is checked against the pre-edge state, so a lock arriving
  // together with a write never blocks that write.
  assign w_tgt_locked = |(w_wr_sel & locked);
  assign w_wr_ok      = my_wr && w_wr_in_range && !w_tgt_locked;
  assign w_lock_ok    = lock && w_wr_in_range;
  assign w_err_next   = (my_wr && !w_wr_ok) || (lock && !w_wr_in_range);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] r_active;
      logic [DW-1:0] r_shadow;
      logic          r_locked;
      logic          w_wr_hit;
      logic          w_lk_hit;

      assign w_wr_sel[gi] = (wr_addr == AW'(gi));
      assign w_wr_hit     = w_wr_ok && w_wr_sel[gi];
      assign w_lk_hit     = w_lock_ok && w_wr_sel[gi];

      // Per-register shadow/active/lock update; reset discards pending shadows
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_active <= RST_VAL;
          r_shadow <= RST_VAL;
          r_locked <= 1'b0;
        end else begin
          if (SHADOW) begin
            if (w_wr_hit) begin
              r_shadow <= Data;
            end
            // Write+lock on this register pushes the new value straight to
            // active so the frozen value is the one just written.
            if (w_wr_hit && w_lk_hit) begin
              r_active <= Data;
            end else if (commit) begin
              r_active <= r_shadow;
            end
          end else begin
            if (w_wr_hit) begin
              r_active <= Data;
            end
          end
          if (w_lk_hit) begin
            r_locked <= 1'b1;
          end
        end
      end

      assign regs_flat[gi*DW +: DW] = r_active;
      assign locked[gi]             = r_locked;
      assign w_rd_terms[gi]         = (rd_addr == AW'(gi)) ? r_active : '0;
    end
  endgenerate

  // Read mux: one-hot terms OR'ed together; out-of-range addresses give zero
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NREG; i++) begin
      w_rd_word = w_rd_word | w_rd_terms[i];
    end
    if (!w_rd_in_range) begin
      w_rd_word = '0;
    end
  end

  // Registered read port and error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_word;
      end
      r_wr_err <= w_err_next;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign wr_err   = r_wr_err;

endmodule
